counter_stim_gen: RTL

Self-running stimulus generator that drives the 4-bit up/down/load counter and its scoreboard from the producing side of the shared `D`/`modo`/`enable` interface. On `start` it plays a fixed, repeatable sequence of rounds: load a pseudo-random value, count up, count down by 1, count down by 3, with idle gaps between phases. It replaces hand-written initial-block stimulus in the counter testbench and is synthesizable, so the same sequence can run on the board.

---
 rtl/counter_stim_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/counter_stim_gen.sv
// counter_stim_gen: self-running stimulus source for the 4-bit up/down/load
// counter. Each round plays LOAD, UP, GAP1, DOWN, GAP2, DOWN3, GAP3; a run is
// ROUNDS rounds followed by a one-cycle DONE pulse. All outputs are registered.
module counter_stim_gen #(
  parameter int         UP_LEN    = 20,
  parameter int         DOWN_LEN  = 20,
  parameter int         DOWN3_LEN = 12,
  parameter int         GAP_LEN   = 2,
  parameter int         ROUNDS    = 4,
  parameter logic [3:0] LFSR_SEED = 4'b1001
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       hold_i,
  output logic [3:0] D_o,
  output logic [1:0] modo_o,
  output logic       enable_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] round_o
);

  localparam int         CNT_W    = 16;
  // An all-zero LFSR would lock up, so a zero seed is replaced by 0001.
  localparam logic [3:0] SEED_EFF = (LFSR_SEED == 4'd0) ? 4'd1 : LFSR_SEED;
  localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_UP, S_GAP1, S_DOWN, S_GAP2, S_DOWN3, S_GAP3, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       lfsr_q;
  logic [3:0]       round_q, round_d;
  logic [3:0]       d_q;
  logic [1:0]       modo_q;
  logic             enable_q, busy_q, done_q;
  logic             freeze;

  // Dwell length of each timed state; LOAD and the control states last one cycle.
  function automatic int phase_len(input state_t s);
    case (s)
      S_UP:                     return UP_LEN;
      S_DOWN:                   return DOWN_LEN;
      S_DOWN3:                  return DOWN3_LEN;
      S_GAP1, S_GAP2, S_GAP3:   return GAP_LEN;
      default:                  return 1;
    endcase
  endfunction

  // Order of states inside a round; S_IDLE here stands for "end of round".
  function automatic state_t succ(input state_t s);
    case (s)
      S_LOAD:  return S_UP;
      S_UP:    return S_GAP1;
      S_GAP1:  return S_DOWN;
      S_DOWN:  return S_GAP2;
      S_GAP2:  return S_DOWN3;
      S_DOWN3: return S_GAP3;
      default: return S_IDLE;
    endcase
  endfunction

  // Next state in round order, skipping any zero-length phase or gap so that
  // a skipped phase costs no cycle at all.
  function automatic state_t next_phase(input state_t s);
    state_t n;
    n = succ(s);
    for (int i = 0; i < 6; i++) begin
      if (n != S_IDLE && phase_len(n) == 0) n = succ(n);
    end
    return n;
  endfunction

  // Next-state and round bookkeeping; hold freezes everything outside IDLE/DONE.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    freeze  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          round_d = 4'd0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (hold_i) begin
          freeze = 1'b1;
        end else if (state_q == S_LOAD || cnt_q == '0) begin
          state_d = next_phase(state_q);
          if (state_d == S_IDLE) begin
            round_d = round_q + 4'd1;
            state_d = (round_d == ROUNDS_L) ? S_DONE : S_LOAD;
          end
        end
      end
    endcase
  end

  // Sequencer state, dwell counter, LFSR and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= SEED_EFF;
      round_q  <= 4'd0;
      d_q      <= 4'd0;
      modo_q   <= 2'b00;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (freeze) begin
      // The pending advance is deferred, so the stalled cycle is not lost.
      enable_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      if (state_d != state_q) begin
        cnt_q <= CNT_W'(phase_len(state_d) - 1);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == S_LOAD) begin
        lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      end
      if (state_d == S_LOAD) begin
        d_q <= lfsr_q;
      end
      case (state_d)
        S_LOAD:  modo_q <= 2'b11;
        S_UP:    modo_q <= 2'b00;
        S_DOWN:  modo_q <= 2'b01;
        S_DOWN3: modo_q <= 2'b10;
        default: modo_q <= modo_q;
      endcase
      enable_q <= (state_d == S_LOAD) || (state_d == S_UP) ||
                  (state_d == S_DOWN) || (state_d == S_DOWN3);
      busy_q   <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign D_o      = d_q;
  assign modo_o   = modo_q;
  assign enable_o = enable_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign round_o  = round_q;

endmodule
